// File: rtl/merged_frame_checker_if.sv
// Merged-stream bundle for merged_frame_checker. The master drives din.
// The slave (the checker) drives the framed payload and the per-frame status.
interface merged_frame_checker_if;
  logic [15:0] din;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_eof;
  logic        frame_done;
  logic        frame_ok;
  logic        vb_missing;
  logic [15:0] frame_xor;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  modport master (
    output din,
    input  o_data, o_valid, o_sof, o_eof, frame_done,
    input  frame_ok, vb_missing, frame_xor, frame_cnt, err_cnt
  );

  modport slave (
    input  din,
    output o_data, o_valid, o_sof, o_eof, frame_done,
    output frame_ok, vb_missing, frame_xor, frame_cnt, err_cnt
  );
endinterface

// File: rtl/merged_frame_checker.sv
// Locks on the CB/VB merged frame header, re-emits the payload with framing and reports per-frame status.
// Optional XOR checksum of the payload is built when FRAME_XOR_EN is defined.
module merged_frame_checker #(
  parameter int          CB_WORDS = 50,
  parameter int          VB_WORDS = 16,
  parameter logic [15:0] HEADER   = 16'hAAAA,
  parameter logic [15:0] TRAILER  = 16'h5554
) (
  input logic                   clk,
  input logic                   rst,
  merged_frame_checker_if.slave bus
);

  localparam logic [6:0] CB_LAST = 7'(CB_WORDS - 1);
  localparam logic [6:0] VB_LAST = 7'(CB_WORDS + VB_WORDS - 1);

  typedef enum logic [1:0] {IDLE, CB, VB, TRL} state_t;

  state_t      state, state_next;
  logic [6:0]  idx, idx_next, idx_inc;
  logic        vb_nz, vb_nz_next;
  logic        emit, sof_set, eof_set, done_set, trl_good;

  logic [15:0] o_data_q;
  logic        o_valid_q, o_sof_q, o_eof_q, frame_done_q;
  logic        frame_ok_q, vb_missing_q;
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  assign idx_inc = idx + 7'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      vb_nz        <= 1'b0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      o_sof_q      <= 1'b0;
      o_eof_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      vb_missing_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      vb_nz        <= vb_nz_next;
      o_valid_q    <= emit;
      o_sof_q      <= sof_set;
      o_eof_q      <= eof_set;
      frame_done_q <= done_set;
      if (emit) begin
        o_data_q <= bus.din;
      end
      if (done_set) begin
        frame_ok_q   <= trl_good;
        vb_missing_q <= !vb_nz;
        frame_cnt_q  <= frame_cnt_q + 16'd1;
        if (!trl_good && err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  // Header words seen outside IDLE are plain data; only IDLE can start a frame.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    vb_nz_next = vb_nz;
    case (state)
      IDLE: begin
        if (bus.din == HEADER) begin
          state_next = CB;
          idx_next   = '0;
          vb_nz_next = 1'b0;
        end
      end
      CB: begin
        idx_next = idx_inc;
        if (idx_inc == CB_LAST) begin
          state_next = VB;
        end
      end
      VB: begin
        idx_next   = idx_inc;
        vb_nz_next = vb_nz | (bus.din != 16'h0000);
        if (idx_inc == VB_LAST) begin
          state_next = TRL;
        end
      end
      TRL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    sof_set  = (state == IDLE) && (bus.din == HEADER);
    emit     = sof_set || (state == CB) || (state == VB);
    eof_set  = (state == VB) && (idx_inc == VB_LAST);
    done_set = (state == TRL);
    trl_good = (bus.din == TRAILER);
  end

`ifdef FRAME_XOR_EN
  logic [15:0] xor_acc, frame_xor_q;

  // The header is excluded: the accumulator restarts on the sof word itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_acc     <= '0;
      frame_xor_q <= '0;
    end else begin
      if (sof_set) begin
        xor_acc <= '0;
      end else if (state == CB || state == VB) begin
        xor_acc <= xor_acc ^ bus.din;
      end
      if (done_set) begin
        frame_xor_q <= xor_acc;
      end
    end
  end

  assign bus.frame_xor = frame_xor_q;
`else
  assign bus.frame_xor = 16'h0000;
`endif

  assign bus.o_data     = o_data_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_sof      = o_sof_q;
  assign bus.o_eof      = o_eof_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.vb_missing = vb_missing_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule
